// File: rtl/or1200_cust5_sha3_absorb.sv
// l.cust5 SHA3 absorb front-end: packs operand words into rate-sized blocks, pads the final
// block, hands blocks to an external Keccak-f core and serves the returned digest word by word.
module or1200_cust5_sha3_absorb #(
  parameter int WORD_W      = 32,
  parameter int RATE_BITS   = 576,
  parameter int DIGEST_BITS = 512,
  parameter int SEL_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cust5_valid,
  input  logic [4:0]             cust5_op,
  input  logic [SEL_W-1:0]       cust5_limm,
  input  logic [WORD_W-1:0]      operand_a,
  output logic                   stall,
  output logic [WORD_W-1:0]      result,
  output logic                   done,
  output logic                   err,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic [RATE_BITS-1:0]   blk_data,
  output logic                   blk_first,
  output logic                   blk_last,
  input  logic                   dig_valid,
  input  logic [DIGEST_BITS-1:0] dig_data
);

  localparam int NW   = RATE_BITS / WORD_W;
  localparam int ND   = DIGEST_BITS / WORD_W;
  localparam int BPW  = WORD_W / 8;
  localparam int WC_W = $clog2(NW + 1);

  localparam logic [4:0] OP_HEAD  = 5'b00100;
  localparam logic [4:0] OP_BODY  = 5'b00010;
  localparam logic [4:0] OP_TAIL  = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_SEND      = 3'd2,
    S_PAD       = 3'd3,
    S_SEND_LAST = 3'd4,
    S_WAIT_DIG  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // The operand's top byte is the earliest message byte, but the block is little-endian by byte.
  function automatic logic [WORD_W-1:0] byte_rev(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < BPW; i++) begin
      r[8*i +: 8] = w[WORD_W-1-8*i -: 8];
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [RATE_BITS-1:0]   buf_q, buf_d;
  logic [WC_W-1:0]        wcnt_q, wcnt_d;
  logic                   first_q, first_d;
  logic                   err_q, err_d;
  logic [DIGEST_BITS-1:0] digest_q, digest_d;
  logic [WORD_W-1:0]      result_q, result_d;

  logic busy_s;
  logic stall_s;
  logic acc_s;

  // Stall decode: only the block hand-off and digest wait hold the pipeline.
  always_comb begin
    busy_s  = state_q inside {S_SEND, S_PAD, S_SEND_LAST, S_WAIT_DIG};
    stall_s = cust5_valid & (cust5_op != OP_STORE) & busy_s;
    acc_s   = cust5_valid & ~stall_s;
  end

  // Next-state, buffer packing, padding, digest capture and STORE read-out.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    wcnt_d   = wcnt_q;
    first_d  = first_q;
    err_d    = err_q;
    digest_d = digest_q;
    result_d = result_q;

    if (acc_s && (cust5_op == OP_STORE)) begin
      if (int'(cust5_limm) < ND) begin
        result_d = digest_q[int'(cust5_limm)*WORD_W +: WORD_W];
      end else begin
        result_d = '0;
      end
    end else begin
      result_d = result_q;
    end

    case (state_q)
      S_IDLE, S_DONE, S_FILL: begin
        if (acc_s && (cust5_op == OP_HEAD)) begin
          buf_d                = '0;
          buf_d[WORD_W-1:0]    = byte_rev(operand_a);
          wcnt_d               = WC_W'(1);
          first_d              = 1'b1;
          err_d                = 1'b0;
          state_d              = S_FILL;
        end else if (acc_s && (state_q == S_FILL) && (cust5_op == OP_BODY)) begin
          buf_d[int'(wcnt_q)*WORD_W +: WORD_W] = byte_rev(operand_a);
          wcnt_d = wcnt_q + WC_W'(1);
          if ((wcnt_q + WC_W'(1)) == WC_W'(NW)) begin
            state_d = S_SEND;
          end else begin
            state_d = S_FILL;
          end
        end else if (acc_s && (state_q == S_FILL) && (cust5_op == OP_TAIL)) begin
          state_d = S_PAD;
        end else if (acc_s && ((cust5_op == OP_BODY) || (cust5_op == OP_TAIL))) begin
          err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_SEND: begin
        if (blk_ready) begin
          buf_d   = '0;
          wcnt_d  = '0;
          first_d = 1'b0;
          state_d = S_FILL;
        end else begin
          state_d = S_SEND;
        end
      end
      S_PAD: begin
        // Word-granular messages never put the 0x06 byte on the final byte, but OR keeps 0x86 correct.
        buf_d[int'(wcnt_q)*WORD_W +: 8] = 8'h06;
        buf_d[RATE_BITS-1 -: 8]         = buf_d[RATE_BITS-1 -: 8] | 8'h80;
        state_d                         = S_SEND_LAST;
      end
      S_SEND_LAST: begin
        if (blk_ready) begin
          state_d = S_WAIT_DIG;
        end else begin
          state_d = S_SEND_LAST;
        end
      end
      S_WAIT_DIG: begin
        if (dig_valid) begin
          digest_d = dig_data;
          state_d  = S_DONE;
        end else begin
          state_d = S_WAIT_DIG;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      wcnt_q   <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      digest_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      wcnt_q   <= wcnt_d;
      first_q  <= first_d;
      err_q    <= err_d;
      digest_q <= digest_d;
      result_q <= result_d;
    end
  end

  assign stall     = stall_s;
  assign result    = result_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign blk_valid = (state_q == S_SEND) || (state_q == S_SEND_LAST);
  assign blk_last  = (state_q == S_SEND_LAST);
  assign blk_first = first_q;
  assign blk_data  = buf_q;

endmodule

// File: tb/tb_or1200_cust5_sha3_absorb.sv
// Bench for or1200_cust5_sha3_absorb: directed plus random messages checked against a
// byte-stream padding model, with a second instance at 64-bit word / 1088-bit rate.
module tb_or1200_cust5_sha3_absorb;

  localparam logic [4:0] HEAD = 5'b00100, BODY = 5'b00010, TAIL = 5'b00001, STORE = 5'b01000;
  typedef logic [1087:0] blk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         cust5_valid, stall, done, err, blk_valid, blk_ready, blk_first, blk_last, dig_valid;
  logic [4:0]   cust5_op;
  logic [5:0]   cust5_limm;
  logic [31:0]  operand_a, result;
  logic [575:0] blk_data;
  logic [511:0] dig_data;

  logic          v64, stall64, done64, err64, bv64, br64, bf64, bl64, dv64;
  logic [4:0]    op64;
  logic [5:0]    lm64;
  logic [63:0]   a64, res64;
  logic [1087:0] bd64;
  logic [255:0]  dd64;

  or1200_cust5_sha3_absorb u_dut (
    .clk(clk), .rst(rst), .cust5_valid(cust5_valid), .cust5_op(cust5_op), .cust5_limm(cust5_limm),
    .operand_a(operand_a), .stall(stall), .result(result), .done(done), .err(err),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first),
    .blk_last(blk_last), .dig_valid(dig_valid), .dig_data(dig_data)
  );

  or1200_cust5_sha3_absorb #(.WORD_W(64), .RATE_BITS(1088), .DIGEST_BITS(256), .SEL_W(6)) u_dut64 (
    .clk(clk), .rst(rst), .cust5_valid(v64), .cust5_op(op64), .cust5_limm(lm64),
    .operand_a(a64), .stall(stall64), .result(res64), .done(done64), .err(err64),
    .blk_valid(bv64), .blk_ready(br64), .blk_data(bd64), .blk_first(bf64),
    .blk_last(bl64), .dig_valid(dv64), .dig_data(dd64)
  );

  int errors = 0;
  int checks = 0;

  logic [575:0]  cap_d[$];
  logic          cap_f[$], cap_l[$];
  logic [1087:0] cap64_d[$];
  logic          cap64_f[$], cap64_l[$];

  // Block monitor: records every handshake, sampled between edges.
  always begin
    @(negedge clk);
    #2;
    if (!rst && blk_valid && blk_ready) begin
      cap_d.push_back(blk_data); cap_f.push_back(blk_first); cap_l.push_back(blk_last);
    end
    if (!rst && bv64 && br64) begin
      cap64_d.push_back(bd64); cap64_f.push_back(bf64); cap64_l.push_back(bl64);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input blk_t obs, input blk_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: message bytes, 0x06 after the last byte, zero fill, 0x80 ORed into the last byte.
  function automatic void model_blocks(input byte unsigned msg[$], input int nb, output blk_t blks[$]);
    byte unsigned p[$];
    blk_t v;
    p = msg;
    p.push_back(8'h06);
    while (p.size() % nb != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    blks = {};
    for (int b = 0; b < p.size() / nb; b++) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = p[b*nb+i];
      blks.push_back(v);
    end
  endfunction

  function automatic logic [31:0] exp_store(input logic [511:0] d, input int lm);
    return (lm < 16) ? d[lm*32 +: 32] : 32'h0;
  endfunction

  task automatic wait_accept();
    int n = 0;
    #1;
    while (stall && n < 300) begin @(negedge clk); #1; n++; end
    chk("accept_timeout", blk_t'(n < 300), blk_t'(1'b1));
    @(negedge clk);
    cust5_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [5:0] lm);
    @(negedge clk);
    cust5_valid = 1'b1; cust5_op = op; operand_a = a; cust5_limm = lm;
    wait_accept();
  endtask

  task automatic issue64(input logic [4:0] op, input logic [63:0] a, input logic [5:0] lm);
    int n = 0;
    @(negedge clk);
    v64 = 1'b1; op64 = op; a64 = a; lm64 = lm;
    #1;
    while (stall64 && n < 300) begin @(negedge clk); #1; n++; end
    chk("accept64_timeout", blk_t'(n < 300), blk_t'(1'b1));
    @(negedge clk);
    v64 = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w[$], input int lo, input int hi);
    for (int i = lo; i < hi; i++) issue((i == 0) ? HEAD : BODY, w[i], 6'd0);
  endtask

  task automatic wait_last(input bit wide);
    int n = 0;
    while (n < 400 && !(wide ? (cap64_l.size() > 0 && cap64_l[$]) : (cap_l.size() > 0 && cap_l[$]))) begin
      @(negedge clk); n++;
    end
    chk("last_block_timeout", blk_t'(n < 400), blk_t'(1'b1));
  endtask

  task automatic check_blocks(input string tag, input logic [31:0] w[$]);
    byte unsigned b[$];
    blk_t exp[$];
    foreach (w[i]) for (int k = 3; k >= 0; k--) b.push_back(w[i][8*k +: 8]);
    model_blocks(b, 72, exp);
    chk({tag, "_nblk"}, blk_t'(cap_d.size()), blk_t'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_d.size(); i++) begin
      chk({tag, "_data"}, blk_t'(cap_d[i]), exp[i]);
      chk({tag, "_first"}, blk_t'(cap_f[i]), blk_t'(i == 0));
      chk({tag, "_last"}, blk_t'(cap_l[i]), blk_t'(i == exp.size() - 1));
    end
  endtask

  task automatic finish_dig(input logic [511:0] dig);
    @(negedge clk);
    dig_valid = 1'b1; dig_data = dig;
    @(negedge clk);
    dig_valid = 1'b0; dig_data = ~dig;
    #1;
    chk("done_after_dig", blk_t'(done), blk_t'(1'b1));
  endtask

  task automatic hash32(input string tag, input logic [31:0] w[$], input logic [511:0] dig);
    cap_d = {}; cap_f = {}; cap_l = {};
    feed(w, 0, w.size());
    issue(TAIL, 32'h0, 6'd0);
    wait_last(1'b0);
    check_blocks(tag, w);
    finish_dig(dig);
  endtask

  task automatic store_chk(input string tag, input int lm, input logic [511:0] dig);
    issue(STORE, 32'h0, 6'(lm));
    chk(tag, blk_t'(result), blk_t'(exp_store(dig, lm)));
  endtask

  string fox = "The quick brown fox jumps over the lazy dog.";
  logic [31:0]  fw[$], w[$];
  logic [63:0]  w64[$];
  logic [511:0] dig, dig_fox;
  logic [575:0] b0, held;
  byte unsigned bb[$];
  blk_t e64[$];

  initial begin
    rst = 1'b1; cust5_valid = 1'b0; cust5_op = 5'd0; cust5_limm = 6'd0; operand_a = 32'd0;
    blk_ready = 1'b1; dig_valid = 1'b0; dig_data = '0;
    v64 = 1'b0; op64 = 5'd0; lm64 = 6'd0; a64 = 64'd0; br64 = 1'b1; dv64 = 1'b0; dd64 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_flags", blk_t'({stall, done, err, blk_valid, blk_first, blk_last}), blk_t'(6'b0));
    chk("reset_result", blk_t'(result), blk_t'(32'h0));
    chk("reset_blk_data", blk_t'(blk_data), blk_t'(576'h0));

    // Fox message: exactly one padded block.
    for (int i = 0; i < 11; i++) fw.push_back({fox[4*i], fox[4*i+1], fox[4*i+2], fox[4*i+3]});
    dig_fox = {8{64'h0123456789abcdef}};
    hash32("fox", fw, dig_fox);
    b0 = cap_d[0];
    chk("fox_byte0", blk_t'(b0[7:0]), blk_t'(8'h54));
    chk("fox_byte43", blk_t'(b0[351:344]), blk_t'(8'h2E));
    chk("fox_byte44", blk_t'(b0[359:352]), blk_t'(8'h06));
    chk("fox_byte71", blk_t'(b0[575:568]), blk_t'(8'h80));
    chk("fox_bytes45_70", blk_t'(b0[567:360]), blk_t'(208'h0));
    store_chk("store_l15", 15, dig_fox);
    chk("store_l15_const", blk_t'(result), blk_t'(32'h01234567));
    store_chk("store_l14", 14, dig_fox);
    chk("store_l14_const", blk_t'(result), blk_t'(32'h89abcdef));
    store_chk("store_l20", 20, dig_fox);

    // BODY in DONE flags an error; dig_valid outside WAIT_DIG is ignored.
    issue(BODY, 32'h1, 6'd0);
    chk("err_body_in_done", blk_t'({err, done}), blk_t'(2'b11));
    issue(HEAD, 32'h2, 6'd0);
    chk("err_clr_head", blk_t'({err, done}), blk_t'(2'b00));
    @(negedge clk); dig_valid = 1'b1; dig_data = ~dig_fox;
    @(negedge clk); dig_valid = 1'b0;
    store_chk("dig_ignored", 15, dig_fox);

    // 18 words: full block, then a pad-only block.
    w = {};
    for (int i = 0; i < 18; i++) w.push_back($urandom);
    dig = {16{32'hA5A5_0000 + 32'(18)}};
    hash32("w18", w, dig);
    store_chk("w18_store3", 3, dig);

    // Core back-pressure while a BODY waits.
    w = {};
    for (int i = 0; i < 19; i++) w.push_back($urandom);
    cap_d = {}; cap_f = {}; cap_l = {};
    blk_ready = 1'b0;
    feed(w, 0, 18);
    @(negedge clk);
    cust5_valid = 1'b1; cust5_op = BODY; operand_a = w[18];
    #1;
    held = blk_data;
    for (int k = 0; k < 5; k++) begin
      chk("bp_stall", blk_t'({stall, blk_valid, blk_first, blk_last}), blk_t'(4'b1110));
      chk("bp_data_stable", blk_t'(blk_data), blk_t'(held));
      @(negedge clk); #1;
    end
    blk_ready = 1'b1;
    wait_accept();
    issue(TAIL, 32'h0, 6'd0);
    wait_last(1'b0);
    check_blocks("bp", w);
    dig = '0;
    for (int k = 0; k < 16; k++) dig[32*k +: 32] = $urandom;
    finish_dig(dig);

    // Reset mid-message.
    w = {};
    for (int i = 0; i < 5; i++) w.push_back($urandom | 32'h1);
    feed(w, 0, 5);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_flags", blk_t'({stall, done, err, blk_valid, blk_first, blk_last}), blk_t'(6'b0));
    chk("rst_result", blk_t'(result), blk_t'(32'h0));
    chk("rst_blk_data", blk_t'(blk_data), blk_t'(576'h0));
    @(negedge clk); rst = 1'b0;
    store_chk("rst_digest_cleared", 2, 512'h0);

    // BODY in IDLE: error, no block.
    cap_d = {}; cap_f = {}; cap_l = {};
    issue(BODY, 32'hDEAD_BEEF, 6'd0);
    repeat (3) @(negedge clk);
    chk("idle_body_err", blk_t'({err, blk_valid}), blk_t'(2'b10));
    chk("idle_body_noblk", blk_t'(cap_d.size()), blk_t'(0));
    hash32("fox2", fw, dig_fox);
    chk("fox2_err", blk_t'(err), blk_t'(1'b0));
    store_chk("fox2_store0", 0, dig_fox);

    // Random messages.
    for (int r = 0; r < 5; r++) begin
      w = {};
      for (int i = 0; i < $urandom_range(1, 40); i++) w.push_back($urandom);
      for (int k = 0; k < 16; k++) dig[32*k +: 32] = $urandom;
      hash32("rand", w, dig);
      for (int s = 0; s < 3; s++) store_chk("rand_store", $urandom_range(0, 20), dig);
    end

    // 64-bit words at rate 1088: 17 words fill exactly one block.
    w64 = {};
    for (int i = 0; i < 17; i++) w64.push_back({$urandom, $urandom});
    for (int i = 0; i < 17; i++) issue64((i == 0) ? HEAD : BODY, w64[i], 6'd0);
    issue64(TAIL, 64'h0, 6'd0);
    wait_last(1'b1);
    bb = {};
    foreach (w64[i]) for (int k = 7; k >= 0; k--) bb.push_back(w64[i][8*k +: 8]);
    model_blocks(bb, 136, e64);
    chk("w64_nblk", blk_t'(cap64_d.size()), blk_t'(2));
    if (cap64_d.size() == 2) begin
      chk("w64_blk0", cap64_d[0], e64[0]);
      chk("w64_blk1", cap64_d[1], e64[1]);
      chk("w64_blk1_const", cap64_d[1], {8'h80, 1072'h0, 8'h06});
      chk("w64_flags", blk_t'({cap64_f[0], cap64_l[0], cap64_f[1], cap64_l[1]}), blk_t'(4'b1001));
    end
    @(negedge clk); dv64 = 1'b1; dd64 = {64'h1111, 64'h2222, 64'h3333, 64'h4444};
    @(negedge clk); dv64 = 1'b0;
    issue64(STORE, 64'h0, 6'd2);
    chk("w64_store2", blk_t'({done64, res64}), blk_t'({1'b1, 64'h2222}));
    issue64(STORE, 64'h0, 6'd5);
    chk("w64_store5", blk_t'(res64), blk_t'(64'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
